scale_factor_adapt: RTL
=======================

Name: scale_factor_adapt

Overview:
- Stateful scale-factor adaptation loop of the G.726/G.721 ADPCM datapath.
- Owns the fast (YU) and slow (YL) scale-factor registers and performs the mixing (MIX) step to produce Y for the quantizer.
- Consumes the log multiplier WI, then runs the FILTD → LIMB → FILTE update: YUP feeds the slow filter and YLP is written back.
- Sequential: serial shift-add multiplier plus a two-phase handshake per sample.

Parameters:
- YU_INIT, 544, reset value of YU (13-bit).
- YL_INIT, 34816, reset value of YL (19-bit, YU_INIT<<6).
- YU_MIN, 544, LIMB lower bound.
- YU_MAX, 5120, LIMB upper bound.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
- start  in  1  request Y for a new sample; accepted only in IDLE.
- al  in  7  speed-control factor AL, 0..64, sampled with start.
- wi  in  12  two's-complement log multiplier WI; sampled with wi_valid.
- wi_valid  in  1  WI present; accepted only in WAIT_WI.
- y  out  13  mixed scale factor Y, registered, held until the next Y update.
- y_valid  out  1  one-cycle pulse when y is updated.
- done  out  1  one-cycle pulse when YU/YL write-back completes.
- busy  out  1  high in every state except IDLE.
- yu_out  out  13  current YU register.
- yl_out  out  19  current YL register.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; YU=YU_INIT, YL=YL_INIT, y=544.
  - y_valid=0, done=0, busy=0; multiplier accumulator and counter cleared.
- States: IDLE, MUL, FIN, WAIT_WI, UPD1, UPD2.
- IDLE, on start=1 at edge k:
  - latch al.
  - compute DIF=(YU+16384-(YL>>6))&16383 and DIFS=DIF[13].
  - DIFM = DIFS ? (16384-DIF)&8191 : DIF.
  - clear accumulator; go to MUL.
- MUL (edges k+1..k+7):
  - one AL bit per cycle, LSB first: acc += bit ? DIFM<<i : 0.
  - 3-bit counter; exit to FIN after bit 6.
- FIN (edge k+8):
  - PRODM=acc>>6; PROD = DIFS ? (16384-PRODM)&16383 : PRODM.
  - y=((YL>>6)+PROD)&8191; y_valid=1 for exactly the following cycle; go to WAIT_WI.
- Y latency: start accepted at edge k → y_valid high between edges k+8 and k+9.
- WAIT_WI, on wi_valid=1 at edge m: latch wi; go to UPD1.
- UPD1 (edge m+1), FILTD:
  - DIF=((wi<<5)+131072-y)&131071 (17-bit).
  - DIFSX = DIF[16] ? (DIF>>5)+4096 : DIF>>5.
  - YUT=(y+DIFSX)&8191.
- UPD1 (edge m+1), LIMB:
  - YUP = YUT<YU_MIN (GELL) ? YU_MIN : YUT>=YU_MAX ? YU_MAX : YUT.
  - Compare modular as in G.726: GELL=((YUT+15840)&16383)>>13, GEUL=((YUT+11264)&16383)>>13.
  - YU←YUP.
- UPD2 (edge m+2), FILTE using the new YU and old YL:
  - DIF=(YU+((1048576-YL)>>6))&16383.
  - DIFSX = DIF[13] ? DIF+507904 : DIF.
  - YL←(YL+DIFSX)&524287.
  - done=1 for the next cycle; go to IDLE.
- Handshake and boundary rules:
  - start outside IDLE: ignored, no queuing.
  - wi_valid outside WAIT_WI: ignored.
  - start and wi_valid together in IDLE: start accepted, wi_valid dropped.
  - WAIT_WI waits indefinitely; y and al are held.
  - al>64 is out of range; the datapath still computes a 7-bit product with no saturation.
  - All arithmetic uses modular masks exactly as stated; no overflow flags.
- Reset mid-operation (any state): immediate return to reset state; a partial update is discarded, so YU/YL never hold a half-written sample.

Test Plan:
- Reset, start al=0 → y_valid after 9 cycles, y=544; wi=0 → done, yu_out=544, yl_out=34816 (fixed point).
- From reset, start al=64 → y=544; wi=1100 → yu_out=1627, yl_out=35899; next start al=64 → y=1627, al=0 → y=560, al=32 → y=1093.
- From reset, wi=0xFF4 (-12) → YUT=515 clamps to yu_out=544.
- Repeat samples with wi=1144 → yu_out rises monotonically, reaches 5120 and stays there (YUT=6104 clamps).
- Handshake/boundary:
  - start pulsed during MUL → ignored; y_valid pulses once.
  - wi_valid during IDLE → no state change.
  - start+wi_valid in the same IDLE cycle → only Y phase runs.
- Drive reset=0 asynchronously mid-UPD1 and mid-MUL → outputs return to reset values within the same cycle; busy=0; no done pulse.

Source files
------------

// File: rtl/scale_factor_adapt.sv
// G.726/G.721 scale-factor adaptation: mixes the fast (YU) and slow (YL) scale
// factors into Y through a serial multiplier, then runs FILTD/LIMB/FILTE on WI.
module scale_factor_adapt #(
   parameter logic [12:0] YU_INIT = 13'd544,
   parameter logic [18:0] YL_INIT = 19'd34816,
   parameter logic [12:0] YU_MIN  = 13'd544,
   parameter logic [12:0] YU_MAX  = 13'd5120
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [6:0]  al,
   input  logic [11:0] wi,
   input  logic        wi_valid,
   output logic [12:0] y,
   output logic        y_valid,
   output logic        done,
   output logic        busy,
   output logic [12:0] yu_out,
   output logic [18:0] yl_out
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_MUL     = 3'd1,
      ST_FIN     = 3'd2,
      ST_WAIT_WI = 3'd3,
      ST_UPD1    = 3'd4,
      ST_UPD2    = 3'd5
   } state_e;

   // Offsets that move the LIMB thresholds onto bit 13 of a 14-bit modular sum.
   localparam logic [13:0] GELL_OFS = 14'(15'd16384 - {2'b00, YU_MIN});
   localparam logic [13:0] GEUL_OFS = 14'(15'd16384 - {2'b00, YU_MAX});

   // MIX difference YU - (YL >> 6), modulo 2^14.
   function automatic logic [13:0] mix_dif(input logic [12:0] yu_v, input logic [18:0] yl_v);
      mix_dif = {1'b0, yu_v} - {1'b0, 13'(yl_v >> 6)};
   endfunction

   // FILTD: fast filter, returns the unlimited YUT.
   function automatic logic [12:0] filtd(input logic [11:0] wi_v, input logic [12:0] y_v);
      logic [16:0] dif;
      logic [12:0] difsx;
      dif   = {wi_v, 5'b00000} - {4'b0000, y_v};
      difsx = 13'(dif >> 5) + (dif[16] ? 13'd4096 : 13'd0);
      filtd = y_v + difsx;
   endfunction

   // LIMB: clamp YUT into [YU_MIN, YU_MAX] using the modular compares.
   function automatic logic [12:0] limb(input logic [12:0] yut);
      logic [13:0] gell_sum;
      logic [13:0] geul_sum;
      gell_sum = {1'b0, yut} + GELL_OFS;
      geul_sum = {1'b0, yut} + GEUL_OFS;
      if (gell_sum >= 14'd8192) begin
         limb = YU_MIN;
      end else if (geul_sum < 14'd8192) begin
         limb = YU_MAX;
      end else begin
         limb = yut;
      end
   endfunction

   // FILTE: slow filter; 2^20 - YL is taken modulo 2^20 since only 14 bits survive.
   function automatic logic [18:0] filte(input logic [12:0] yu_v, input logic [18:0] yl_v);
      logic [19:0] neg_yl;
      logic [13:0] dif;
      logic [18:0] difsx;
      neg_yl = 20'd0 - {1'b0, yl_v};
      dif    = {1'b0, yu_v} + 14'(neg_yl >> 6);
      difsx  = {5'b00000, dif} + (dif[13] ? 19'd507904 : 19'd0);
      filte  = yl_v + difsx;
   endfunction

   state_e      state_q, state_d;
   logic [6:0]  al_q, al_d;
   logic [12:0] difm_q, difm_d;
   logic        difs_q, difs_d;
   logic [19:0] acc_q, acc_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [12:0] y_q, y_d;
   logic [11:0] wi_q, wi_d;
   logic [12:0] yu_q, yu_d;
   logic [18:0] yl_q, yl_d;
   logic        y_valid_q, done_q, busy_q;

   logic [13:0] dif_s, negdif_s;
   logic [13:0] prodm_s, negprod_s, prod_s;
   logic [19:0] pp_s;

   // Next-state and datapath decode for every FSM state.
   always_comb begin
      state_d = state_q;
      al_d    = al_q;
      difm_d  = difm_q;
      difs_d  = difs_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
      wi_d    = wi_q;
      yu_d    = yu_q;
      yl_d    = yl_q;

      dif_s     = mix_dif(yu_q, yl_q);
      negdif_s  = 14'd0 - dif_s;
      prodm_s   = 14'(acc_q >> 6);
      negprod_s = 14'd0 - prodm_s;
      prod_s    = difs_q ? negprod_s : prodm_s;
      pp_s      = al_q[cnt_q] ? ({7'd0, difm_q} << cnt_q) : 20'd0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               al_d    = al;
               difs_d  = dif_s[13];
               difm_d  = dif_s[13] ? 13'(negdif_s) : 13'(dif_s);
               acc_d   = 20'd0;
               cnt_d   = 3'd0;
               state_d = ST_MUL;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MUL: begin
            acc_d = acc_q + pp_s;
            if (cnt_q == 3'd6) begin
               cnt_d   = 3'd0;
               state_d = ST_FIN;
            end else begin
               cnt_d   = cnt_q + 3'd1;
               state_d = ST_MUL;
            end
         end
         ST_FIN: begin
            y_d     = 13'(yl_q >> 6) + 13'(prod_s);
            state_d = ST_WAIT_WI;
         end
         ST_WAIT_WI: begin
            if (wi_valid) begin
               wi_d    = wi;
               state_d = ST_UPD1;
            end else begin
               state_d = ST_WAIT_WI;
            end
         end
         ST_UPD1: begin
            yu_d    = limb(filtd(wi_q, y_q));
            state_d = ST_UPD2;
         end
         ST_UPD2: begin
            yl_d    = filte(yu_q, yl_q);
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers and registered status outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         al_q      <= 7'd0;
         difm_q    <= 13'd0;
         difs_q    <= 1'b0;
         acc_q     <= 20'd0;
         cnt_q     <= 3'd0;
         y_q       <= YU_INIT;
         wi_q      <= 12'd0;
         yu_q      <= YU_INIT;
         yl_q      <= YL_INIT;
         y_valid_q <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         al_q      <= al_d;
         difm_q    <= difm_d;
         difs_q    <= difs_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         y_q       <= y_d;
         wi_q      <= wi_d;
         yu_q      <= yu_d;
         yl_q      <= yl_d;
         y_valid_q <= (state_q == ST_FIN);
         done_q    <= (state_q == ST_UPD2);
         busy_q    <= (state_d != ST_IDLE);
      end
   end

   assign y       = y_q;
   assign y_valid = y_valid_q;
   assign done    = done_q;
   assign busy    = busy_q;
   assign yu_out  = yu_q;
   assign yl_out  = yl_q;

endmodule
